// File: rtl/control_fsm.sv
// control_fsm: multicycle control sequencer for the 32-bit RISC-V core.
// Walks each instruction through fetch/decode/execute/memory/writeback and
// drives every datapath enable and mux select from the current state.
module control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_src,
  output logic       illegal
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11
  } state_t;

  state_t state_q;
  state_t state_d;

  logic pc_update;
  logic branch;
  logic ir_en;
  logic mem_en;
  logic reg_en;
  logic illegal_dec;

  // State register; reset parks the sequencer in FETCH immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic and Moore decode of enables and mux selects.
  always_comb begin
    state_d     = S_FETCH;
    pc_update   = 1'b0;
    branch      = 1'b0;
    ir_en       = 1'b0;
    mem_en      = 1'b0;
    reg_en      = 1'b0;
    illegal_dec = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_en      = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          OP_LUI:       state_d = S_LUI;
          default: begin
            state_d     = S_FETCH;
            illegal_dec = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        if (op == OP_LW)      state_d = S_MEMREAD;
        else if (op == OP_SW) state_d = S_MEMWRITE;
        else                  state_d = S_FETCH;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_en     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_en  = 1'b1;
        state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_en  = 1'b1;
        state_d = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Immediate format select depends only on the opcode, not on the state.
  always_comb begin
    case (op)
      OP_SW:   imm_src = 3'b001;
      OP_BEQ:  imm_src = 3'b010;
      OP_LUI:  imm_src = 3'b011;
      OP_JAL:  imm_src = 3'b100;
      default: imm_src = 3'b000;
    endcase
  end

  // Write strobes are gated by reset so an in-flight write dies at once.
  assign pc_write  = ~reset & (pc_update | (branch & zero));
  assign ir_write  = ~reset & ir_en;
  assign mem_write = ~reset & mem_en;
  assign reg_write = ~reset & reg_en;
  assign illegal   = ~reset & illegal_dec;

endmodule

// File: doc/control_fsm.md
# control_fsm

Multicycle control sequencer for the 32-bit RISC-V core. It steps each instruction through fetch, decode, execute, memory and writeback states. It drives every datapath enable and mux select, including `imm_src`, which feeds the `extend_ctrl` input of the immediate extender. It sits between the instruction register (opcode field) and the shared ALU/memory/register-file datapath.

## Interface
- No parameters.
- `clk` input 1 — single clock; all state updates on the rising edge.
- `reset` input 1 — asynchronous, active-high; forces state to FETCH.
- `op` input 7 — instruction-register bits [6:0].
- `zero` input 1 — ALU zero flag, used by the branch decision.
- `pc_write` output 1 — PC register enable.
- `ir_write` output 1 — instruction-register and old-PC register enable.
- `adr_src` output 1 — memory address select: 0 = PC, 1 = ALU result register.
- `mem_write` output 1 — data memory write strobe.
- `reg_write` output 1 — register-file write enable.
- `result_src` output 2 — result mux select: 00 = ALU out register, 01 = memory data register, 10 = live ALU result.
- `alu_src_a` output 2 — ALU operand A select: 00 = PC, 01 = old PC, 10 = rs1, 11 = constant 0.
- `alu_src_b` output 2 — ALU operand B select: 00 = rs2, 01 = immediate, 10 = constant 4.
- `alu_op` output 2 — ALU decoder class: 00 = add, 01 = subtract (compare), 10 = use funct fields.
- `imm_src` output 3 — extender control: 000 = I, 001 = S, 010 = B, 011 = U, 100 = J.
- `illegal` output 1 — one-cycle pulse in DECODE when the opcode is not supported.

## Operation
- **Supported opcodes:**
  - lw 0000011
  - sw 0100011
  - R-type 0110011
  - I-ALU 0010011
  - beq 1100011
  - jal 1101111
  - lui 0110111
- **`imm_src` decode.** Combinational from `op`: lw/I-ALU → 000, sw → 001, beq → 010, lui → 011, jal → 100, any other opcode → 000.
- **Moore outputs.** All other outputs are Moore outputs of the state. Any signal not listed for a state is 0.
- **`pc_write`.** `pc_write` = `pc_update` | (`branch` & `zero`), where `pc_update` and `branch` are internal state-decoded signals.
- **States and transitions:**
  - **FETCH:** `ir_write`=1, `alu_src_a`=00, `alu_src_b`=10, `result_src`=10, `pc_update`=1 → DECODE.
  - **DECODE:** `alu_src_a`=01, `alu_src_b`=01 (precomputes the branch/jump target). Next state by opcode:
    - lw, sw → MEMADR
    - R-type → EXECR
    - I-ALU → EXECI
    - beq → BEQ
    - jal → JAL
    - lui → LUI
    - any other opcode → FETCH, with `illegal`=1.
  - **MEMADR:** `alu_src_a`=10, `alu_src_b`=01 → MEMREAD if lw, MEMWRITE if sw.
  - **MEMREAD:** `adr_src`=1, `result_src`=00 → MEMWB.
  - **MEMWB:** `result_src`=01, `reg_write`=1 → FETCH.
  - **MEMWRITE:** `adr_src`=1, `result_src`=00, `mem_write`=1 → FETCH.
  - **EXECR:** `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10 → ALUWB.
  - **EXECI:** `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10 → ALUWB.
  - **ALUWB:** `result_src`=00, `reg_write`=1 → FETCH.
  - **BEQ:** `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00, `branch`=1 → FETCH.
  - **JAL:** `alu_src_a`=01, `alu_src_b`=10, `result_src`=00, `pc_update`=1 → ALUWB (writes PC+4 to rd).
  - **LUI:** `alu_src_a`=11, `alu_src_b`=01 → ALUWB.
- **Unreachable state encodings.** Unused state codes return to FETCH on the next edge with all outputs 0.

## Timing
- **Cycles per instruction (FETCH to next FETCH):**
  - lw: 5
  - sw: 4
  - R-type / I-ALU: 4
  - beq: 3
  - jal: 4
  - lui: 4
  - illegal opcode: 2
- **Opcode sampling.** `op` is sampled combinationally in DECODE and MEMADR. The IR is stable after FETCH because `ir_write` is only asserted in FETCH.
- **Branch decision.** `zero` is sampled combinationally in BEQ only. `pc_write` follows `zero` within the same cycle.
- **Reset values while `reset`=1:**
  - state = FETCH.
  - `pc_write`, `ir_write`, `mem_write`, `reg_write`, `illegal` are forced to 0.
  - Mux selects show their FETCH values: `alu_src_b`=10, `result_src`=10, all other selects 00.
  - `imm_src` follows `op`.
- **Reset release.** The first fetch write occurs on the first rising edge after `reset` deasserts.
- **Reset mid-instruction.** Reset asserted mid-instruction (e.g. in MEMWRITE) drops `mem_write` immediately (asynchronously). No partial writeback completes.

## Test plan
- **Reset then lw.** Hold `reset` 2 cycles, release, `op`=0000011 (lw x1,4(x2), 0x00412083).
  - States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH.
  - `imm_src`=000.
  - `reg_write`=1 only in MEMWB, with `result_src`=01.
- **sw.** `op`=0100011 (0x00112223).
  - 4 cycles; `mem_write`=1 exactly once, with `adr_src`=1.
  - `imm_src`=001.
  - `reg_write` never asserted.
- **beq taken and not taken.** `op`=1100011 (0x00208463), `imm_src`=010.
  - `zero`=1 in BEQ → `pc_write`=1 in that cycle.
  - `zero`=0 → `pc_write`=0.
  - Both cases return to FETCH after 3 cycles.
- **add, jal, lui.**
  - add, `op`=0110011 (0x002081B3): EXECR `alu_op`=10, `alu_src_b`=00, then ALUWB `reg_write`=1.
  - jal, `op`=1101111 (0x0080006F): `imm_src`=100; JAL asserts `pc_write`; ALUWB writes rd.
  - lui, `op`=0110111 (0x123450B7): `imm_src`=011; LUI `alu_src_a`=11.
- **Illegal opcode.** `op`=1111111: DECODE asserts `illegal`=1 for one cycle, next state is FETCH, and no write enable is asserted.
- **Reset mid-instruction.** Assert `reset` asynchronously during MEMWRITE.
  - `mem_write` drops to 0 before the next edge.
  - After release, state is FETCH and `ir_write`=1 on the first cycle.
